// File: rtl/dds_fm_ctrl_pkg.sv
// Shared types and helpers for the DDS FM modulation controller.
package dds_fm_pkg;

  typedef enum logic [1:0] {IDLE, ARMED, MUL, ADD} fm_state_e;

  localparam int unsigned DEF_NBITS       = 13;
  localparam int unsigned DEF_NBITS_AUDIO = 12;
  localparam int unsigned DEF_NBITS_KDEV  = 8;
  localparam int unsigned SAT_W           = 32;

  // Signed sample times zero-extended gain needs one extra bit.
  function automatic int unsigned prod_width(input int unsigned nbits_audio,
                                             input int unsigned nbits_kdev);
    return nbits_audio + nbits_kdev + 1;
  endfunction

  function automatic int unsigned sum_width(input int unsigned nbits);
    return nbits + 2;
  endfunction

  function automatic logic [SAT_W-1:0] sat_unsigned(input logic signed [SAT_W-1:0] sum,
                                                    input int unsigned nbits);
    logic [SAT_W-1:0] max_v;
    max_v = (SAT_W'(1) << nbits) - SAT_W'(1);
    if (sum < 0) return '0;
    if (sum > $signed(max_v)) return max_v;
    return sum;
  endfunction

endpackage

// File: rtl/dds_fm_ctrl_if.sv
// Audio sample valid/ready stream into the FM controller.
interface dds_fm_ctrl_if
  import dds_fm_pkg::*;
#(
  parameter int unsigned NBITS_AUDIO = DEF_NBITS_AUDIO
);
  logic signed [NBITS_AUDIO-1:0] s_data;
  logic                          s_valid;
  logic                          s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/dds_fm_ctrl_clk_enable_div.sv
// Free-running enable divider: one-cycle tick every DIV cycles while run is high.
module clk_enable_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic tick
);
  localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!run)              cnt_d = '0;
    else if (cnt_q == LAST) cnt_d = '0;
    else                    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = run && (cnt_q == LAST);
endmodule

// File: rtl/dds_fm_ctrl.sv
// FM sequencer for the DDS: enable cadence, sample intake and saturated phaseinc.
module dds_fm_ctrl
  import dds_fm_pkg::*;
#(
  parameter int unsigned NBITS       = DEF_NBITS,
  parameter int unsigned NBITS_AUDIO = DEF_NBITS_AUDIO,
  parameter int unsigned NBITS_KDEV  = DEF_NBITS_KDEV,
  parameter int unsigned KSHIFT      = 6,
  parameter int unsigned ENDIV       = 4,
  parameter int unsigned SAMPLEDIV   = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  run,
  input  logic [NBITS-1:0]      carrier_inc,
  input  logic [NBITS_KDEV-1:0] kdev,
  dds_fm_ctrl_if.slave          s_if,
  output logic                  enableclk,
  output logic [NBITS-1:0]      phaseinc,
  output logic                  underrun,
  input  logic                  clear_underrun
);
  localparam int unsigned   PROD_W   = prod_width(NBITS_AUDIO, NBITS_KDEV);
  localparam int unsigned   SUM_W    = sum_width(NBITS);
  localparam int unsigned   SW       = (SAMPLEDIV > 1) ? $clog2(SAMPLEDIV) : 1;
  localparam logic [SW-1:0] SMP_LAST = SW'(SAMPLEDIV - 1);

  clk_enable_div #(.DIV(ENDIV)) u_en_div (
    .clock (clock),
    .reset (reset),
    .run   (run),
    .tick  (enableclk)
  );

  logic [SW-1:0] smp_cnt_q;
  logic          sample_due;

  assign sample_due = enableclk && (smp_cnt_q == SMP_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)          smp_cnt_q <= '0;
    else if (!run)      smp_cnt_q <= '0;
    else if (enableclk) smp_cnt_q <= (smp_cnt_q == SMP_LAST) ? '0 : smp_cnt_q + 1'b1;
  end

  fm_state_e                     state_q;
  logic                          buf_full_q;
  logic signed [NBITS_AUDIO-1:0] buf_q, sample_q;
  logic signed [PROD_W-1:0]      prod_q, prod_d;
  logic signed [SUM_W-1:0]       shifted, sum_d;
  logic [NBITS-1:0]              phaseinc_q, phaseinc_d;
  logic                          underrun_q;
  logic                          handshake;

  // Ready depends only on registered state, never on s_valid.
  assign s_if.s_ready = (state_q != IDLE) && !buf_full_q;
  assign handshake    = s_if.s_valid && s_if.s_ready;

  always_comb begin
    prod_d     = PROD_W'(sample_q) * PROD_W'($signed({1'b0, kdev}));
    shifted    = SUM_W'(prod_q >>> KSHIFT);
    sum_d      = $signed(SUM_W'(carrier_inc)) + shifted;
    phaseinc_d = NBITS'(sat_unsigned(SAT_W'(sum_d), NBITS));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      sample_q   <= '0;
      prod_q     <= '0;
      phaseinc_q <= '0;
      underrun_q <= 1'b0;
    end else begin
      // A new underrun outranks a simultaneous clear request.
      if (sample_due && (state_q == ARMED) && !buf_full_q) underrun_q <= 1'b1;
      else if (clear_underrun)                              underrun_q <= 1'b0;

      if (!run) begin
        state_q    <= IDLE;
        buf_full_q <= 1'b0;
        phaseinc_q <= carrier_inc;
      end else begin
        if (handshake) begin
          buf_full_q <= 1'b1;
          buf_q      <= s_if.s_data;
        end
        unique case (state_q)
          IDLE: begin
            phaseinc_q <= carrier_inc;
            state_q    <= ARMED;
          end
          ARMED: begin
            if (sample_due && buf_full_q) begin
              sample_q   <= buf_q;
              buf_full_q <= 1'b0;
              state_q    <= MUL;
            end
          end
          MUL: begin
            prod_q  <= prod_d;
            state_q <= ADD;
          end
          ADD: begin
            phaseinc_q <= phaseinc_d;
            state_q    <= ARMED;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign phaseinc = phaseinc_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_dds_fm_ctrl.sv
// Scoreboard bench for dds_fm_ctrl with ENDIV=4, SAMPLEDIV=4, KSHIFT=6.
module tb_dds_fm_ctrl;
  localparam int unsigned NBITS       = 13;
  localparam int unsigned NBITS_AUDIO = 12;
  localparam int unsigned NBITS_KDEV  = 8;
  localparam int unsigned KSHIFT      = 6;
  localparam int unsigned ENDIV       = 4;
  localparam int unsigned SAMPLEDIV   = 4;
  localparam int          PH_MAX      = (1 << NBITS) - 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  run = 1'b0;
  logic                  clear_und = 1'b0;
  logic [NBITS-1:0]      carrier_inc = '0;
  logic [NBITS_KDEV-1:0] kdev = '0;
  logic                  enableclk;
  logic [NBITS-1:0]      phaseinc;
  logic                  underrun;

  dds_fm_ctrl_if #(.NBITS_AUDIO(NBITS_AUDIO)) s_bus ();

  dds_fm_ctrl #(
    .NBITS(NBITS), .NBITS_AUDIO(NBITS_AUDIO), .NBITS_KDEV(NBITS_KDEV),
    .KSHIFT(KSHIFT), .ENDIV(ENDIV), .SAMPLEDIV(SAMPLEDIV)
  ) dut (
    .clock          (clk),
    .reset          (rst),
    .run            (run),
    .carrier_inc    (carrier_inc),
    .kdev           (kdev),
    .s_if           (s_bus),
    .enableclk      (enableclk),
    .phaseinc       (phaseinc),
    .underrun       (underrun),
    .clear_underrun (clear_und)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int calc_ph(input int car, input int smp, input int k);
    int v;
    v = (smp * k) >>> KSHIFT;
    v = car + v;
    if (v < 0)      v = 0;
    if (v > PH_MAX) v = PH_MAX;
    return v;
  endfunction

  // Reference model: state reflects the current cycle once a rising edge has passed.
  int  exp_q[$];
  int  en_m = 0, smp_m = 0, ph_m = 0;
  bit  armed_m = 0, buf_m = 0, p1_m = 0, p2_m = 0, und_m = 0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      en_m = 0; smp_m = 0; ph_m = 0;
      armed_m = 0; buf_m = 0; p1_m = 0; p2_m = 0; und_m = 0;
      exp_q.delete();
    end else begin
      bit hs, tick, due, set_und;
      hs      = s_bus.s_valid && armed_m && !buf_m;
      tick    = run && (en_m == ENDIV - 1);
      due     = tick && (smp_m == SAMPLEDIV - 1);
      set_und = 0;
      if (!run) begin
        armed_m = 0; buf_m = 0; p1_m = 0; p2_m = 0;
        en_m = 0; smp_m = 0;
        exp_q.delete();
        ph_m = int'(carrier_inc);
      end else begin
        if (!armed_m)  ph_m = int'(carrier_inc);
        else if (p2_m) ph_m = exp_q.pop_front();
        p2_m = p1_m;
        p1_m = 0;
        if (armed_m && due) begin
          if (buf_m) begin buf_m = 0; p1_m = 1; end
          else set_und = 1;
        end
        if (hs) begin
          exp_q.push_back(calc_ph(int'(carrier_inc), int'($signed(s_bus.s_data)), int'(kdev)));
          buf_m = 1;
        end
        if (tick) smp_m = (smp_m == SAMPLEDIV - 1) ? 0 : smp_m + 1;
        en_m    = (en_m == ENDIV - 1) ? 0 : en_m + 1;
        armed_m = 1;
      end
      if (set_und)        und_m = 1;
      else if (clear_und) und_m = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check_eq("enableclk", enableclk, run && (en_m == ENDIV - 1));
      check_eq("s_ready",   s_bus.s_ready, armed_m && !buf_m);
      check_eq("underrun",  underrun, und_m);
      check_eq("phaseinc",  phaseinc, ph_m);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send(input int val);
    int w = 0;
    s_bus.s_valid = 1'b1;
    s_bus.s_data  = NBITS_AUDIO'(val);
    while (!s_bus.s_ready && w < 60) begin step(1); w++; end
    if (!s_bus.s_ready) check_eq("send_timeout", s_bus.s_ready, 1);
    else step(1);
    s_bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 80) begin step(1); w++; end
    check_eq("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic wait_due_cycle();
    int w = 0;
    while (!(run && en_m == ENDIV - 1 && smp_m == SAMPLEDIV - 1) && w < 40) begin step(1); w++; end
    check_eq("due_timeout", w < 40, 1);
  endtask

  int vals[8] = '{7, -7, 1000, -1000, 2047, -2048, 333, -1};

  initial begin
    int pulses, first_edge, w;
    s_bus.s_valid = 1'b0;
    s_bus.s_data  = '0;
    carrier_inc   = 13'd4096;
    kdev          = 8'd64;
    step(3);
    check_eq("rst_enableclk", enableclk, 0);
    check_eq("rst_phaseinc",  phaseinc, 0);
    check_eq("rst_s_ready",   s_bus.s_ready, 0);
    check_eq("rst_underrun",  underrun, 0);
    rst = 1'b0;
    step(3);
    check_eq("idle_phaseinc", phaseinc, 4096);

    // Cadence: the DDS consumes pulses on edges ENDIV, 2*ENDIV, ... after run rises.
    run = 1'b1;
    pulses = 0;
    first_edge = 0;
    for (int i = 1; i <= 16; i++) begin
      step(1);
      if (enableclk) begin
        pulses++;
        if (first_edge == 0) first_edge = i + 1;
      end
    end
    check_eq("cadence_first", first_edge, ENDIV);
    check_eq("cadence_count", pulses, 16 / ENDIV);
    run = 1'b0;
    step(6);
    check_eq("stop_enableclk", enableclk, 0);
    check_eq("stop_underrun_kept", underrun, 1);
    clear_und = 1'b1; step(1); clear_und = 1'b0;
    check_eq("clear_underrun", underrun, 0);

    // Nominal and saturation.
    run = 1'b1;
    send(100);   drain(); check_eq("nominal_pos", phaseinc, 4196);
    send(-100);  drain(); check_eq("nominal_neg", phaseinc, 3996);
    carrier_inc = 13'd1000;
    send(-2048); drain(); check_eq("sat_low", phaseinc, 0);
    carrier_inc = 13'd8000; kdev = 8'd255;
    send(2047);  drain(); check_eq("sat_high", phaseinc, 8191);

    // Underrun, clear, and clear colliding with a fresh underrun plus a handshake.
    check_eq("pre_underrun", underrun, 0);
    wait_due_cycle(); step(1);
    check_eq("underrun_set", underrun, 1);
    check_eq("underrun_hold_ph", phaseinc, 8191);
    clear_und = 1'b1; step(1); clear_und = 1'b0;
    check_eq("underrun_clr", underrun, 0);
    carrier_inc = 13'd4096; kdev = 8'd64;
    wait_due_cycle();
    clear_und = 1'b1; s_bus.s_valid = 1'b1; s_bus.s_data = 12'sd50;
    step(1);
    clear_und = 1'b0; s_bus.s_valid = 1'b0;
    check_eq("set_beats_clear", underrun, 1);
    check_eq("buffered_on_due", s_bus.s_ready, 0);
    drain(); check_eq("late_sample", phaseinc, 4146);
    clear_und = 1'b1; step(1); clear_und = 1'b0;

    // Back-to-back stream with s_valid held high.
    foreach (vals[i]) send(vals[i]);
    drain();
    check_eq("stream_last", phaseinc, 4095);
    check_eq("stream_no_underrun", underrun, 0);

    // Abort during MUL.
    send(500);
    w = 0;
    while (!p1_m && w < 40) begin step(1); w++; end
    check_eq("mul_timeout", p1_m, 1);
    run = 1'b0;
    step(1);
    check_eq("abort_ph", phaseinc, 4096);
    check_eq("abort_s_ready", s_bus.s_ready, 0);
    step(4);
    check_eq("abort_hold", phaseinc, 4096);
    carrier_inc = 13'd1234; step(1);
    check_eq("idle_track", phaseinc, 1234);
    carrier_inc = 13'd4096;

    // Asynchronous reset in the ADD cycle.
    run = 1'b1;
    w = 0;
    while (!underrun && w < 40) begin step(1); w++; end
    check_eq("rerun_underrun", underrun, 1);
    send(300);
    w = 0;
    while (!p2_m && w < 40) begin step(1); w++; end
    check_eq("add_timeout", p2_m, 1);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_phaseinc",  phaseinc, 0);
    check_eq("arst_underrun",  underrun, 0);
    check_eq("arst_s_ready",   s_bus.s_ready, 0);
    check_eq("arst_enableclk", enableclk, 0);
    run = 1'b0;
    step(2);
    rst = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
